freq_meter: RTL and testbench

Gated frequency meter for the 100 MHz system clock domain. It samples an asynchronous square-wave input, counts its rising edges over a fixed gate window of clock cycles and publishes the count once per window with a one-cycle valid strobe. It is the measuring counterpart of the clock dividers: it checks divided or external clocks against clk_i, and it feeds the display/reporting logic. An optional period counter reports the clk_i cycles between consecutive input edges.

---
 rtl/freq_meter.sv | 121 ++++++++++++
 tb/tb_freq_meter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/freq_meter.sv
// freq_meter: gated frequency meter for the clk_i domain.
// Synchronizes sig_i, counts its rising edges over GATE_CYCLES enabled
// cycles and publishes the count with a one-cycle valid_o strobe.
// Optional period counter built when FREQ_METER_PERIOD_EN is defined;
// otherwise period_o / period_valid_o are tied to 0.
module freq_meter #(
    parameter int GATE_CYCLES = 100000000,
    parameter int CNT_W       = 32,
    parameter int PER_W       = 32
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             en_i,
    input  logic             sig_i,
    output logic [CNT_W-1:0] freq_o,
    output logic             valid_o,
    output logic             ovf_o,
    output logic [PER_W-1:0] period_o,
    output logic             period_valid_o
);

    localparam int GC_W = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
    localparam logic [GC_W-1:0]  GC_LAST = GC_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0] EC_MAX  = '1;

    logic             s1, s2, d;
    logic             sig_rise;
    logic [GC_W-1:0]  gc;
    logic [CNT_W-1:0] ec;
    logic             sat;
    logic             ec_at_max;
    logic             win_end;

    assign sig_rise  = s2 & ~d;
    assign ec_at_max = (ec == EC_MAX);
    assign win_end   = en_i && (gc == GC_LAST);

    // Two-flop synchronizer plus delay flop for rising-edge detection; free-running.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            d  <= 1'b0;
        end else begin
            s1 <= sig_i;
            s2 <= s1;
            d  <= s2;
        end
    end

    // Gate and edge counters; cleared while disabled and at each window end.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            gc  <= '0;
            ec  <= '0;
            sat <= 1'b0;
        end else if (!en_i || win_end) begin
            gc  <= '0;
            ec  <= '0;
            sat <= 1'b0;
        end else begin
            gc <= gc + GC_W'(1);
            if (sig_rise) begin
                if (ec_at_max) sat <= 1'b1;
                else           ec  <= ec + CNT_W'(1);
            end
        end
    end

    // Publish the window result; the edge seen on the last cycle still counts.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            freq_o  <= '0;
            ovf_o   <= 1'b0;
            valid_o <= 1'b0;
        end else begin
            valid_o <= win_end;
            if (win_end) begin
                freq_o <= (sig_rise && !ec_at_max) ? ec + CNT_W'(1) : ec;
                ovf_o  <= sat | (sig_rise & ec_at_max);
            end
        end
    end

`ifdef FREQ_METER_PERIOD_EN
    localparam logic [PER_W-1:0] PC_MAX = '1;

    logic [PER_W-1:0] pc;
    logic             armed;

    // Period counter: first edge after enable only arms; later edges report pc+1.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc             <= '0;
            armed          <= 1'b0;
            period_o       <= '0;
            period_valid_o <= 1'b0;
        end else if (!en_i) begin
            pc             <= '0;
            armed          <= 1'b0;
            period_valid_o <= 1'b0;
        end else begin
            period_valid_o <= 1'b0;
            if (sig_rise) begin
                pc    <= '0;
                armed <= 1'b1;
                if (armed) begin
                    period_o       <= (pc == PC_MAX) ? pc : pc + PER_W'(1);
                    period_valid_o <= 1'b1;
                end
            end else if (pc != PC_MAX) begin
                pc <= pc + PER_W'(1);
            end
        end
    end
`else
    assign period_o       = '0;
    assign period_valid_o = 1'b0;
`endif

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: directed self-checking bench for freq_meter
// (GATE_CYCLES=100, CNT_W=4 so saturation is reachable, PER_W=8).
module tb_freq_meter;

    localparam int GATE = 100;
    localparam int CW   = 4;
    localparam int PW   = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          en = 1'b0;
    logic          sig = 1'b0;
    logic [CW-1:0] freq;
    logic          valid;
    logic          ovf;
    logic [PW-1:0] period;
    logic          period_valid;

    int errors = 0;
    int checks = 0;
    int cyc = 0;
    int half = 0;
    logic hold = 1'b0;
    int t0 = 0;

    freq_meter #(.GATE_CYCLES(GATE), .CNT_W(CW), .PER_W(PW)) dut (
        .clk_i(clk), .rst_ni(rst_n), .en_i(en), .sig_i(sig),
        .freq_o(freq), .valid_o(valid), .ovf_o(ovf),
        .period_o(period), .period_valid_o(period_valid)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc = cyc + 1;

    // Square-wave source: low for half cycles, then high for half, from t0.
    always @(posedge clk) begin
        #2;
        if (half == 0) sig = hold;
        else           sig = (((cyc - t0) / half) % 2) == 1;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
        $fatal(1, "watchdog");
    end

    task automatic set_sig(input int h, input logic v);
        @(posedge clk); #1;
        half = h; hold = v; t0 = cyc;
    endtask

    task automatic set_en(input logic v, output int at);
        @(posedge clk); #1;
        en = v; at = cyc;
    endtask

    task automatic wait_valid(input int budget, output bit found, output int at);
        found = 0; at = -1;
        for (int i = 0; i < budget && !found; i++) begin
            @(negedge clk);
            if (valid === 1'b1) begin found = 1; at = cyc; end
        end
    endtask

    task automatic test_reset();
        #12;
        checks++; if (freq !== '0) begin errors++; $display("FAIL reset_freq: got %0d want 0", freq); end
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", valid); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ovf); end
        checks++; if (period !== '0) begin errors++; $display("FAIL reset_period: got %0d want 0", period); end
        checks++; if (period_valid !== 1'b0) begin errors++; $display("FAIL reset_pvalid: got %b want 0", period_valid); end
        @(posedge clk); #1; rst_n = 1'b1;
    endtask

    task automatic test_basic();
        int c, at, at2; bit f;
        set_sig(5, 1'b0);
        repeat (20) @(posedge clk);
        set_en(1'b1, c);
        wait_valid(150, f, at);
        checks++; if (!f || at != c + GATE) begin errors++; $display("FAIL basic_latency: got cycle %0d want %0d (found=%0b)", at, c + GATE, f); end
        checks++; if (freq !== 4'd10 || ovf !== 1'b0) begin errors++; $display("FAIL basic_first: got freq=%0d ovf=%b want 10/0", freq, ovf); end
        @(negedge clk);
        checks++; if (valid !== 1'b0) begin errors++; $display("FAIL basic_pulse_width: got valid=%b want 0", valid); end
        wait_valid(150, f, at2);
        checks++; if (!f || at2 != at + GATE) begin errors++; $display("FAIL basic_spacing: got cycle %0d want %0d", at2, at + GATE); end
        checks++; if (freq !== 4'd10 || ovf !== 1'b0) begin errors++; $display("FAIL basic_second: got freq=%0d ovf=%b want 10/0", freq, ovf); end
    endtask

    task automatic test_period();
        int c, pulses; bit bad;
        set_en(1'b0, c);
        set_sig(0, 1'b0);
        repeat (10) @(posedge clk);
        set_en(1'b1, c);
        set_sig(5, 1'b0);
        pulses = 0; bad = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
`ifdef FREQ_METER_PERIOD_EN
            if (period_valid === 1'b1) begin
                pulses++;
                checks++; if (period !== 8'd10) begin errors++; $display("FAIL period_value: got %0d want 10", period); end
            end
`else
            if (period_valid !== 1'b0 || period !== '0) bad = 1;
`endif
        end
`ifdef FREQ_METER_PERIOD_EN
        checks++; if (pulses != 4) begin errors++; $display("FAIL period_pulses: got %0d want 4", pulses); end
`else
        checks++; if (bad || pulses != 0) begin errors++; $display("FAIL period_tied: got nonzero period outputs, want 0"); end
`endif
    endtask

    task automatic test_saturation();
        int at; bit f;
        wait_valid(150, f, at);
        set_sig(1, 1'b0);
        wait_valid(150, f, at);
        wait_valid(150, f, at);
        checks++; if (!f || freq !== 4'd15 || ovf !== 1'b1) begin errors++; $display("FAIL sat_fast: got freq=%0d ovf=%b want 15/1", freq, ovf); end
        set_sig(10, 1'b0);
        wait_valid(150, f, at);
        wait_valid(150, f, at);
        checks++; if (!f || freq !== 4'd5 || ovf !== 1'b0) begin errors++; $display("FAIL sat_recover: got freq=%0d ovf=%b want 5/0", freq, ovf); end
    endtask

    task automatic test_enable_gap();
        int c, at; bit f, bad;
        set_sig(5, 1'b0);
        wait_valid(150, f, at);
        wait_valid(150, f, at);
        checks++; if (!f || freq !== 4'd10) begin errors++; $display("FAIL gap_pre: got freq=%0d want 10", freq); end
        repeat (49) @(posedge clk);
        set_en(1'b0, c);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (valid !== 1'b0 || freq !== 4'd10) bad = 1;
        end
        checks++; if (bad) begin errors++; $display("FAIL gap_hold: got valid or freq change while disabled, want none"); end
        set_en(1'b1, c);
        wait_valid(150, f, at);
        checks++; if (!f || at != c + GATE) begin errors++; $display("FAIL gap_restart: got cycle %0d want %0d", at, c + GATE); end
        checks++; if (freq !== 4'd10) begin errors++; $display("FAIL gap_freq: got %0d want 10", freq); end
    endtask

    task automatic test_const_high();
        int at, pv; bit f;
        set_sig(0, 1'b1);
        wait_valid(150, f, at);
        f = 0; pv = 0;
        for (int i = 0; i < 150 && !f; i++) begin
            @(negedge clk);
            if (period_valid === 1'b1) pv++;
            if (valid === 1'b1) f = 1;
        end
        checks++; if (!f || freq !== 4'd0 || ovf !== 1'b0) begin errors++; $display("FAIL const_freq: got freq=%0d ovf=%b want 0/0", freq, ovf); end
        checks++; if (pv != 0) begin errors++; $display("FAIL const_pvalid: got %0d pulses want 0", pv); end
    endtask

    task automatic test_reset_mid();
        int c, at; bit f;
        set_sig(5, 1'b0);
        wait_valid(150, f, at);
        wait_valid(150, f, at);
        repeat (60) @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (freq !== '0 || ovf !== 1'b0 || valid !== 1'b0 || period !== '0) begin
            errors++; $display("FAIL midreset_outputs: got freq=%0d ovf=%b valid=%b period=%0d want all 0", freq, ovf, valid, period);
        end
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1; c = cyc;
        wait_valid(150, f, at);
        checks++; if (!f || at != c + GATE) begin errors++; $display("FAIL midreset_latency: got cycle %0d want %0d", at, c + GATE); end
        wait_valid(150, f, at);
        checks++; if (!f || freq !== 4'd10) begin errors++; $display("FAIL midreset_next: got freq=%0d want 10", freq); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_period();
        test_saturation();
        test_enable_gap();
        test_const_high();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
